// File: rtl/decoder_pkg.sv
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types and constants for the multiplexed hex display
//               scanner: FSM state encoding, segment width, hex glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

    // Number of segment lines (a..g), bit0 = a
    localparam int c_SEG_W = 7;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Glyph table, element [n] is the segment pattern for nibble n
    localparam logic [15:0][c_SEG_W-1:0] c_GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage : decoder_pkg

`default_nettype wire

// File: rtl/decoder_scan_hex7seg.sv
// ============================================================================
// Module      : hex7seg
// Description : Combinational nibble-to-seven-segment glyph lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
    import decoder_pkg::*;
(
    input  logic [3:0]         i_nibble,
    output logic [c_SEG_W-1:0] o_seg
);

    // Straight table lookup, active-high segments
    assign o_seg = c_GLYPH_TABLE[i_nibble];

endmodule : hex7seg

`default_nettype wire

// File: rtl/decoder_scan.sv
// ============================================================================
// Module      : decoder_scan
// Description : Time-multiplexed hex display driver. A shadow register takes
//               loads at any time; its content moves to the displayed value
//               only at frame start so a frame never shows mixed data.
//               Optional macro DECODER_SCAN_LZB_EN enables leading-zero
//               blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan
    import decoder_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ON_CYCLES   = 1024,
    parameter int DEAD_CYCLES = 16,
    parameter int ACT_LOW     = 0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   io_in,
    output logic [c_SEG_W-1:0]    seg_o,
    output logic [DIGITS-1:0]     dig_o,
    output logic                  frame_done_o
);

    localparam int c_CNT_MAX = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam bit c_HAS_DEAD = (DEAD_CYCLES > 0);
    localparam logic c_INV    = (ACT_LOW != 0);

    localparam logic [c_CNT_W-1:0] c_ON_LAST   = c_CNT_W'(ON_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DEAD_LAST = c_CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_DIG_LAST  = c_IDX_W'(DIGITS - 1);

    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_ON   = ST_ON;
    localparam logic [1:0] c_ST_DEAD = ST_DEAD;

    localparam logic [c_SEG_W-1:0] c_SEG_OFF = {c_SEG_W{c_INV}};
    localparam logic [DIGITS-1:0]  c_DIG_OFF = {DIGITS{c_INV}};

    logic [1:0]            r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                  w_frame_start;
    logic                  w_slot_end;
    logic                  w_frame_done;

    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_active;
    logic                  r_pending;

    logic [3:0]            w_nibble;
    logic [c_SEG_W-1:0]    w_glyph;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_onehot;

    logic [c_SEG_W-1:0]    r_seg;
    logic [DIGITS-1:0]     r_dig;
    logic                  r_frame_done;

    // Next-state, prescaler and digit index; frame start is entry to digit 0 ON
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_frame_start = 1'b0;
        w_slot_end    = 1'b0;
        if (!enable) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt   = c_ST_ON;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_frame_start = 1'b1;
                end
                c_ST_ON: begin
                    if (r_cnt == c_ON_LAST) begin
                        w_cnt_nxt = '0;
                        if (c_HAS_DEAD) begin
                            w_state_nxt = c_ST_DEAD;
                        end else begin
                            w_slot_end = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_ST_DEAD: begin
                    if (r_cnt == c_DEAD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_ON;
                        w_slot_end  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
            if (w_slot_end) begin
                if (r_idx == c_DIG_LAST) begin
                    w_idx_nxt     = '0;
                    w_frame_start = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    assign w_frame_done = w_slot_end && (r_idx == c_DIG_LAST);

    // FSM state registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Shadow/active registers; a load on the frame-start cycle goes straight through
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_frame_start) begin
            if (load) begin
                r_shadow <= io_in;
                r_active <= io_in;
            end else if (r_pending) begin
                r_active <= r_shadow;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow  <= io_in;
            r_pending <= 1'b1;
        end
    end

    // Select the nibble of the digit currently being scanned
    always_comb begin
        w_nibble = r_active[{r_idx, 2'b00} +: 4];
    end

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

`ifdef DECODER_SCAN_LZB_EN
    logic [c_IDX_W-1:0] w_msnz;

    // Blank digits above the most significant nonzero nibble; digit 0 always shown
    always_comb begin
        w_msnz = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_active[4*k +: 4] != 4'h0) begin
                w_msnz = c_IDX_W'(k);
            end
        end
        w_blank = (r_idx > w_msnz);
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_onehot = DIGITS'(1) << r_idx;

    // Registered outputs: lit only while ON and enabled, dark otherwise
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_seg        <= c_SEG_OFF;
            r_dig        <= c_DIG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            if (enable && (r_state == c_ST_ON)) begin
                r_seg <= (w_blank ? '0 : w_glyph) ^ c_SEG_OFF;
                r_dig <= w_onehot ^ c_DIG_OFF;
            end else begin
                r_seg <= c_SEG_OFF;
                r_dig <= c_DIG_OFF;
            end
            r_frame_done <= w_frame_done;
        end
    end

    assign seg_o        = r_seg;
    assign dig_o        = r_dig;
    assign frame_done_o = r_frame_done;

endmodule : decoder_scan

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ============================================================================
// Module      : tb_decoder_scan
// Description : Scoreboard bench for decoder_scan. Two instances share the
//               stimulus: (ON=4, DEAD=1, active-high) and (ON=3, DEAD=0,
//               active-low). A positional reference model predicts outputs.
//               Honours DECODER_SCAN_LZB_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        ld  = 1'b0;
    logic [15:0] io  = 16'h0;

    logic [6:0]  seg0, seg1;
    logic [3:0]  dig0, dig1;
    logic        fd0, fd1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decoder_scan #(.DIGITS(4), .ON_CYCLES(4), .DEAD_CYCLES(1), .ACT_LOW(0)) u_dut0 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable       (en),
        .load         (ld),
        .io_in        (io),
        .seg_o        (seg0),
        .dig_o        (dig0),
        .frame_done_o (fd0)
    );

    decoder_scan #(.DIGITS(4), .ON_CYCLES(3), .DEAD_CYCLES(0), .ACT_LOW(1)) u_dut1 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable       (en),
        .load         (ld),
        .io_in        (io),
        .seg_o        (seg1),
        .dig_o        (dig1),
        .frame_done_o (fd1)
    );

    // Reference model state, one entry per instance
    int          on_c   [2] = '{4, 3};
    int          dead_c [2] = '{1, 0};
    bit          inv_c  [2] = '{1'b0, 1'b1};
    bit          running[2] = '{1'b0, 1'b0};
    int          pos    [2] = '{0, 0};
    logic [15:0] shadow [2] = '{16'h0, 16'h0};
    logic [15:0] active [2] = '{16'h0, 16'h0};
    bit          pending[2] = '{1'b0, 1'b0};

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t q0[$];
    exp_t q1[$];

    // Frame-start handover of displayed data
    task automatic frame_start(input int i);
        if (ld) begin
            shadow[i] = io;
            active[i] = io;
        end else if (pending[i]) begin
            active[i] = shadow[i];
        end
        pending[i] = 1'b0;
    endtask

    // Model one clock edge: compute the output registered at this edge
    task automatic model_edge(input int i, output exp_t e);
        int slot, d, o;
        logic [15:0] upper;
        bit blank;
        slot  = on_c[i] + dead_c[i];
        e.seg = {7{inv_c[i]}};
        e.dig = {4{inv_c[i]}};
        e.fd  = 1'b0;
        if (rst) begin
            running[i] = 0; pos[i] = 0;
            shadow[i] = '0; active[i] = '0; pending[i] = 0;
        end else if (!en) begin
            running[i] = 0; pos[i] = 0;
            if (ld) begin shadow[i] = io; pending[i] = 1; end
        end else if (!running[i]) begin
            running[i] = 1; pos[i] = 0;
            frame_start(i);
        end else begin
            d = (pos[i] / slot) % 4;
            o = pos[i] % slot;
            upper = active[i] >> (4 * d);
            blank = 1'b0;
`ifdef DECODER_SCAN_LZB_EN
            blank = (d > 0) && (upper == 16'h0);
`endif
            if (o < on_c[i]) begin
                e.dig = 4'(1 << d) ^ {4{inv_c[i]}};
                e.seg = (blank ? 7'h00 : glyph_tab[upper[3:0]]) ^ {7{inv_c[i]}};
            end
            e.fd = (d == 3) && (o == slot - 1);
            pos[i] = (pos[i] + 1) % (slot * 4);
            if (pos[i] == 0) frame_start(i);
            else if (ld) begin shadow[i] = io; pending[i] = 1; end
        end
    endtask

    // Producer: predict each instance's next registered output
    always @(posedge clk) begin
        exp_t e;
        model_edge(0, e); q0.push_back(e);
        model_edge(1, e); q1.push_back(e);
    end

    // Monitor: compare DUT outputs against queued predictions mid-cycle
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {seg0, dig0, fd0};
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL dut0_out t=%0t got seg=%h dig=%b fd=%b want seg=%h dig=%b fd=%b",
                         $time, a.seg, a.dig, a.fd, e.seg, e.dig, e.fd);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {seg1, dig1, fd1};
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL dut1_out t=%0t got seg=%h dig=%b fd=%b want seg=%h dig=%b fd=%b",
                         $time, a.seg, a.dig, a.fd, e.seg, e.dig, e.fd);
            end
        end
    end

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        ld = 1'b1; io = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Stimulus
    initial begin
        int r;
        rst = 1'b1; en = 1'b0; ld = 1'b0; io = 16'h0;
        cycles(3);
        rst = 1'b0;
        // Basic scan with a preloaded value
        do_load(16'h12AF);
        en = 1'b1;
        cycles(45);
        // Mid-frame load of zeros, held until next frame start
        do_load(16'h0000);
        cycles(45);
        do_load(16'h3C5D);
        cycles(30);
        // Reset during an active frame, released with enable high
        cycles(11);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(25);
        // Enable dropped mid digit 1, then restored
        do_load(16'h9876);
        cycles(26);
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(25);
        // Leading-zero pattern
        do_load(16'h0007);
        cycles(45);
        // Load on a frame-start cycle while idle (bypass)
        en = 1'b0;
        cycles(2);
        en = 1'b1; ld = 1'b1; io = 16'hB0E4;
        cycles(1);
        ld = 1'b0;
        cycles(30);
        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            r   = $urandom_range(0, 999);
            rst = (r < 5);
            en  = ($urandom_range(0, 29) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            io  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) io[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) io[7:4]  = 4'h0;
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; ld = 1'b0;
        cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_decoder_scan

`default_nettype wire
